sc_nadder_ctrl: RTL and testbench
=================================

# sc_nadder_ctrl

Sequencing controller for the stochastic N-input adder (mux-based scaled adder). It accepts a stream-length command, drives the adder's select lines for exactly that many cycles, and counts the ones on the adder output. It then returns the binary count through a valid/ready handshake. It sits between the binary-domain control logic and a stochastic adder plus its input stream generators, and replaces free-running select-stream sources.

## Interface
- INPUT_STREAMS, 4, number of adder inputs; power of 2, ≥2
- SELECT_WIDTH, 2, select width; must equal log2(INPUT_STREAMS)
- LENGTH_WIDTH, 16, width of stream length and result
- SEED, 16'hACE1, nonzero LFSR seed (LFSR mode only)

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin a run; sampled only in IDLE
- length  in  LENGTH_WIDTH  stream length L in cycles; sampled with start
- busy  out  1  high in RUN and DONE
- stream_en  out  1  high in RUN only; advances upstream stream generators
- sel  out  SELECT_WIDTH  adder select; 0 outside RUN
- sum_bit  in  1  adder output; sampled every RUN cycle
- result  out  LENGTH_WIDTH  count of ones over the run
- result_valid  out  1  result available (DONE)
- result_ready  in  1  consumer accepts result

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 and length≠0 → latch L into the remaining counter, clear the ones count, reload the sel source, go to RUN.
  - start=1 with length=0 is ignored; the block stays in IDLE.
- RUN:
  - stream_en=1, and sel is driven from the sel source.
  - Each edge: count += sum_bit, remaining -= 1, sel source advances.
  - The edge on which remaining==1 is the last count edge; the next state is DONE.
- DONE:
  - result_valid=1; result equals the final count and is held stable.
  - result_valid&&result_ready at an edge → IDLE.
- start is ignored in RUN and DONE. length changes after the start edge have no effect.
- Arithmetic: count ≤ L ≤ 2^LENGTH_WIDTH−1, so no overflow and no saturation logic is needed. The adder value estimate is result/L; scaling by INPUT_STREAMS is the consumer's job.
- Sel source is selected by the macro in Configuration.
- Reset (any time, including mid-RUN): state=IDLE immediately. busy, stream_en, sel, result, result_valid all go to 0, and the counters are cleared. No partial result is produced.

## Timing
- sum_bit is treated as combinational from sel. The bit counted at an edge corresponds to the sel value present during the preceding cycle.
- For a start sampled at edge E0: RUN occupies the cycles after edges E0..E(L−1); result_valid rises after edge E(L). Latency is start-to-valid = L+1 cycles.
- If result_ready is already high, result_valid lasts 1 cycle. IDLE follows, and the next start can be sampled on the following edge, giving a minimum spacing of L+2 cycles.
- All outputs are registered except sel, which is state-gated register bits.

## Configuration
- SC_NADDER_CTRL_LFSR_EN defined (random mode):
  - sel[i] is bit 0 of a private 16-bit Fibonacci LFSR, one per select bit, with polynomial x^16+x^14+x^13+x^11+1.
  - Seed for sel[i] is SEED rotated left by 4·i, reloaded on every accepted start.
  - Each select bit is ~0.5 and the bits are mutually decorrelated, giving an unbiased stochastic scaled add.
- SC_NADDER_CTRL_LFSR_EN undefined (round-robin mode):
  - sel is a binary counter cleared on an accepted start and incremented each RUN cycle, wrapping modulo INPUT_STREAMS. This gives sel = 0,1,…,N−1,0,…
  - The result is exact when L is a multiple of INPUT_STREAMS.
  - No LFSR logic is synthesized.

## Test plan
- Round-robin, N=4, sum_bit=x[sel] with x=4'b0011, start with L=8 → sel 0,1,2,3,0,1,2,3; stream_en high 8 cycles; result_valid 9 cycles after start with result=4.
- start with length=0 → busy, stream_en and result_valid stay 0 for 20 cycles; a following start with L=4 runs normally.
- L=4, result_ready low 5 cycles after valid → result_valid and result held constant; start pulses during RUN and DONE are ignored; IDLE the cycle after ready rises.
- rst_n asserted during the 3rd RUN cycle → all outputs 0 without waiting for a clock edge. After release, start with L=4 and x=4'b1111 → result=4.
- LFSR mode, x=all ones, L=1000 → result=1000. x=0 → result=0. x=4'b0001, L=65535 → result within 16384±600, and each sel bit is high 50%±1%.
- Either mode, x=all ones, L=65535 → result=65535 with no wrap; result_valid 65536 cycles after start.

Source files
------------

// File: rtl/sc_nadder_ctrl.sv
`default_nettype none
// ==========================================================================
// sc_nadder_ctrl: run-length sequencer for a mux-based stochastic adder; macro SC_NADDER_CTRL_LFSR_EN
// selects LFSR-driven selects (default: round-robin counter). Revision 1.0
// ==========================================================================
module sc_nadder_ctrl #(
  parameter int          INPUT_STREAMS = 4,
  parameter int          SELECT_WIDTH  = 2,
  parameter int          LENGTH_WIDTH  = 16,
  parameter logic [15:0] SEED          = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [LENGTH_WIDTH-1:0] length,
  output logic                    busy,
  output logic                    stream_en,
  output logic [SELECT_WIDTH-1:0] sel,
  input  logic                    sum_bit,
  output logic [LENGTH_WIDTH-1:0] result,
  output logic                    result_valid,
  input  logic                    result_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state;
  logic [LENGTH_WIDTH-1:0] remaining;
  logic [LENGTH_WIDTH-1:0] count;
  logic [SELECT_WIDTH-1:0] sel_src;
  logic                    accept;
  logic                    advance;

  if ((INPUT_STREAMS < 2) || ((1 << SELECT_WIDTH) != INPUT_STREAMS)) begin : g_bad_width
    $error("INPUT_STREAMS must be a power of 2 >= 2 and equal 2**SELECT_WIDTH");
  end
  if (SEED == 16'h0000) begin : g_bad_seed
    $error("SEED must be nonzero");
  end

  assign accept  = (state == IDLE) && start && (length != '0);
  assign advance = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      remaining    <= '0;
      count        <= '0;
      result       <= '0;
      busy         <= 1'b0;
      stream_en    <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            remaining <= length;
            count     <= '0;
            busy      <= 1'b1;
            stream_en <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          count     <= count + LENGTH_WIDTH'(sum_bit);
          remaining <= remaining - LENGTH_WIDTH'(1);
          // Final count edge: capture the total including this cycle's bit.
          if (remaining == LENGTH_WIDTH'(1)) begin
            result       <= count + LENGTH_WIDTH'(sum_bit);
            stream_en    <= 1'b0;
            result_valid <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: begin
          if (result_ready) begin
            busy         <= 1'b0;
            result_valid <= 1'b0;
            state        <= IDLE;
          end
        end
        default: begin
          busy         <= 1'b0;
          stream_en    <= 1'b0;
          result_valid <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

`ifdef SC_NADDER_CTRL_LFSR_EN
  for (genvar i = 0; i < SELECT_WIDTH; i++) begin : g_lfsr
    localparam int          ROT       = (4 * i) % 16;
    localparam logic [15:0] LANE_SEED = 16'((SEED << ROT) | (SEED >> ((16 - ROT) % 16)));
    logic [15:0] lfsr;

    // Fibonacci x^16+x^14+x^13+x^11+1, one private register per select bit.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        lfsr <= LANE_SEED;
      end else if (accept) begin
        lfsr <= LANE_SEED;
      end else if (advance) begin
        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      end
    end

    assign sel_src[i] = lfsr[0];
  end
`else
  // Wraps modulo INPUT_STREAMS naturally since it is 2**SELECT_WIDTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_src <= '0;
    end else if (accept) begin
      sel_src <= '0;
    end else if (advance) begin
      sel_src <= sel_src + SELECT_WIDTH'(1);
    end
  end
`endif

  assign sel = advance ? sel_src : '0;

endmodule
`default_nettype wire

// File: tb/tb_sc_nadder_ctrl.sv
`default_nettype none
// tb_sc_nadder_ctrl: scoreboard bench for sc_nadder_ctrl covering sel sequence, counts, handshake and reset.
module tb_sc_nadder_ctrl;
  localparam int          N    = 4;
  localparam int          SW   = 2;
  localparam int          LW   = 16;
  localparam logic [15:0] SEED = 16'hACE1;

  logic          clk          = 1'b0;
  logic          rst_n        = 1'b0;
  logic          start        = 1'b0;
  logic [LW-1:0] length       = '0;
  logic          result_ready = 1'b1;
  logic          busy;
  logic          stream_en;
  logic [SW-1:0] sel;
  logic          sum_bit;
  logic [LW-1:0] result;
  logic          result_valid;
  logic [N-1:0]  xpat         = '0;

  int            compared     = 0;
  int            mismatched   = 0;
  int            sb[$];
  int            sel_ones[SW];
  int            m_k;
  logic [15:0]   m_lf[SW];

  assign sum_bit = xpat[sel];

  always #5 clk = ~clk;

  sc_nadder_ctrl #(
    .INPUT_STREAMS(N),
    .SELECT_WIDTH (SW),
    .LENGTH_WIDTH (LW),
    .SEED         (SEED)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .length      (length),
    .busy        (busy),
    .stream_en   (stream_en),
    .sel         (sel),
    .sum_bit     (sum_bit),
    .result      (result),
    .result_valid(result_valid),
    .result_ready(result_ready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] rotl16(input logic [15:0] v, input int r);
    return (v << r) | (v >> ((16 - r) % 16));
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  task automatic model_reload();
    m_k = 0;
    for (int i = 0; i < SW; i++) m_lf[i] = rotl16(SEED, 4 * i);
  endtask

  function automatic logic [SW-1:0] model_sel();
    logic [SW-1:0] s;
`ifdef SC_NADDER_CTRL_LFSR_EN
    for (int i = 0; i < SW; i++) s[i] = m_lf[i][0];
`else
    s = m_k[SW-1:0];
`endif
    return s;
  endfunction

  task automatic model_advance();
    m_k++;
    for (int i = 0; i < SW; i++) m_lf[i] = lfsr_step(m_lf[i]);
  endtask

  task automatic model_count(input logic [N-1:0] pat, input int len, output int c);
    c = 0;
    model_reload();
    for (int k = 0; k < len; k++) begin
      if (pat[model_sel()]) c++;
      model_advance();
    end
    model_reload();
  endtask

  task automatic run_one(input int len, input logic [N-1:0] pat, input int ready_lag, input bit poke);
    int            cyc;
    int            runs;
    int            sel_bad;
    int            hold_bad;
    int            exp;
    logic [LW-1:0] held;
    xpat         = pat;
    result_ready = (ready_lag == 0);
    for (int i = 0; i < SW; i++) sel_ones[i] = 0;
    @(negedge clk);
    start  = 1'b1;
    length = LW'(len);
    model_count(pat, len, exp);
    sb.push_back(exp);
    @(negedge clk);
    start   = 1'b0;
    length  = LW'($urandom);
    cyc     = 1;
    runs    = 0;
    sel_bad = 0;
    while (!result_valid && cyc <= len + 4) begin
      if (stream_en && busy) runs++;
      if (sel !== model_sel()) sel_bad++;
      for (int i = 0; i < SW; i++) if (sel[i] === 1'b1) sel_ones[i]++;
      model_advance();
      if (poke) start = (cyc == 2);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("latency", cyc, len + 1);
    check("run_cycles", runs, len);
    check("sel_seq", sel_bad, 0);
    check("valid", result_valid, 1);
    check("result", result, sb.pop_front());
    held     = result;
    hold_bad = 0;
    for (int i = 0; i < ready_lag; i++) begin
      if (poke) start = (i == 0);
      @(negedge clk);
      start = 1'b0;
      if (!result_valid || result !== held || !busy || stream_en || sel !== '0) hold_bad++;
    end
    if (ready_lag > 0) check("done_hold", hold_bad, 0);
    result_ready = 1'b1;
    @(negedge clk);
    check("idle_after", {busy, stream_en, result_valid}, 0);
  endtask

  initial begin
    int exp;
    int bad;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_stream_en", stream_en, 0);
    check("rst_sel", sel, 0);
    check("rst_valid", result_valid, 0);
    check("rst_result", result, 0);
    rst_n = 1'b1;

    run_one(8, 4'b0011, 0, 1'b0);

    @(negedge clk);
    start  = 1'b1;
    length = '0;
    @(negedge clk);
    start = 1'b0;
    bad   = 0;
    repeat (20) begin
      if (busy || stream_en || result_valid) bad++;
      @(negedge clk);
    end
    check("zero_len", bad, 0);
    run_one(4, 4'b0110, 0, 1'b0);

    run_one(4, 4'b1010, 5, 1'b1);

    // Reset asserted mid-run, checked before any further clock edge.
    xpat = 4'b0011;
    @(negedge clk);
    start  = 1'b1;
    length = LW'(8);
    model_count(xpat, 8, exp);
    sb.push_back(exp);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_outs", {busy, stream_en, sel, result_valid}, 0);
    check("async_rst_result", result, 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    run_one(4, 4'b1111, 0, 1'b0);

    run_one(1, 4'b1111, 0, 1'b0);
    run_one(1000, 4'b1111, 0, 1'b0);
    run_one(1000, 4'b0000, 0, 1'b0);
    run_one(37, 4'b1001, 2, 1'b0);

`ifdef SC_NADDER_CTRL_LFSR_EN
    run_one(65535, 4'b0001, 0, 1'b0);
    check("lfsr_result_band", (result >= 16'd15784 && result <= 16'd16984), 1);
    for (int i = 0; i < SW; i++)
      check("sel_balance", (sel_ones[i] >= 32112 && sel_ones[i] <= 33423), 1);
`else
    run_one(65535, 4'b1111, 0, 1'b0);
    check("max_len_result", result, 65535);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
